hc112_tester: RTL and testbench

Self-checking exerciser for the dual JK flip-flop block (HC112). It drives both channels' preset, clear, J, K and clock pins from one system clock and reads back Q and Q_N. It compares the read-back against an internal reference model and reports pass/fail, an error count and the first failing step. It is the stimulus/initiator side of the HC112 pin interface and is used on the board and in simulation.

---
 rtl/hc112_tester.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_hc112_tester.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hc112_tester.sv
// rtl/hc112_tester.sv - self-checking stimulus and checker for a dual JK flip-flop (HC112)
module hc112_tester #(
    parameter int         STEPS  = 64,
    parameter int         SETTLE = 2,
    parameter logic [7:0] SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       q1,
    input  logic       q1_n,
    input  logic       q2,
    input  logic       q2_n,
    output logic       s1,
    output logic       s2,
    output logic       r1,
    output logic       r2,
    output logic       j1,
    output logic       k1,
    output logic       j2,
    output logic       k2,
    output logic       clk1,
    output logic       clk2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_cnt,
    output logic [7:0] fail_step
);

    // Settle counter runs 0..SETTLE-1 in each wait state.
    localparam int            CW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SETTLE - 1);
    localparam logic [7:0]    STEP_LAST = 8'(STEPS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT_H,
        ST_FALL,
        ST_WAIT_L,
        ST_CHECK
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    step_q, step_d;
    logic [7:0]    lfsr_q, lfsr_d;
    logic          e1_q, e1_d;
    logic          e2_q, e2_d;
    logic          fail_seen_q, fail_seen_d;
    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          r1_q, r1_d;
    logic          r2_q, r2_d;
    logic          j1_q, j1_d;
    logic          k1_q, k1_d;
    logic          j2_q, j2_d;
    logic          k2_q, k2_d;
    logic          dut_clk_q, dut_clk_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [7:0]    err_q, err_d;
    logic [7:0]    fs_q, fs_d;

    logic [7:0]    lfsr_next;
    logic          vec_s1, vec_s2, vec_r1, vec_r2;
    logic          vec_j1, vec_k1, vec_j2, vec_k2;
    logic          mis1, mis2;
    logic [8:0]    err_sum;

    // Expected flip-flop state after a falling clock with the given J/K.
    function automatic logic jk_next(input logic e, input logic j, input logic k);
        case ({j, k})
            2'b01:   jk_next = 1'b0;
            2'b10:   jk_next = 1'b1;
            2'b11:   jk_next = ~e;
            default: jk_next = e;
        endcase
    endfunction

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1 advance.
    always_comb begin
        lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // Vector for the current step: two fixed init steps, then LFSR-derived.
    always_comb begin
        vec_s1 = 1'b1;
        vec_s2 = 1'b1;
        vec_r1 = 1'b1;
        vec_r2 = 1'b1;
        vec_j1 = 1'b0;
        vec_k1 = 1'b0;
        vec_j2 = 1'b0;
        vec_k2 = 1'b0;
        if (step_q == 8'd0) begin
            vec_r1 = 1'b0;
            vec_r2 = 1'b0;
        end else if (step_q == 8'd1) begin
            vec_s1 = 1'b0;
            vec_s2 = 1'b0;
        end else begin
            vec_j1 = lfsr_q[0];
            vec_k1 = lfsr_q[1];
            vec_j2 = lfsr_q[2];
            vec_k2 = lfsr_q[3];
            vec_s1 = (lfsr_q[7:5] != 3'd0);
            vec_r1 = (lfsr_q[7:5] != 3'd1);
            vec_s2 = (lfsr_q[4:2] != 3'd0);
            vec_r2 = (lfsr_q[4:2] != 3'd1);
        end
    end

    // Per-channel mismatch against the expected bits and saturating error sum.
    always_comb begin
        mis1    = (q1 != e1_q) || (q1_n != ~e1_q);
        mis2    = (q2 != e2_q) || (q2_n != ~e2_q);
        err_sum = 9'(err_q) + 9'(mis1) + 9'(mis2);
    end

    // Sequencer: next-state and registered pin/status values.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        step_d      = step_q;
        lfsr_d      = lfsr_q;
        e1_d        = e1_q;
        e2_d        = e2_q;
        fail_seen_d = fail_seen_q;
        s1_d        = s1_q;
        s2_d        = s2_q;
        r1_d        = r1_q;
        r2_d        = r2_q;
        j1_d        = j1_q;
        k1_d        = k1_q;
        j2_d        = j2_q;
        k2_d        = k2_q;
        dut_clk_d   = dut_clk_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_d       = err_q;
        fs_d        = fs_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_DRIVE;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    err_d       = 8'd0;
                    fs_d        = 8'd0;
                    fail_seen_d = 1'b0;
                    lfsr_d      = SEED;
                    step_d      = 8'd0;
                end
            end
            ST_DRIVE: begin
                s1_d   = vec_s1;
                s2_d   = vec_s2;
                r1_d   = vec_r1;
                r2_d   = vec_r2;
                j1_d   = vec_j1;
                k1_d   = vec_k1;
                j2_d   = vec_j2;
                k2_d   = vec_k2;
                // Preset dominates clear; with both inactive the state holds.
                e1_d   = !vec_s1 ? 1'b1 : (!vec_r1 ? 1'b0 : e1_q);
                e2_d   = !vec_s2 ? 1'b1 : (!vec_r2 ? 1'b0 : e2_q);
                lfsr_d = lfsr_next;
                cnt_d  = '0;
                state_d = ST_WAIT_H;
            end
            ST_WAIT_H: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_FALL;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_FALL: begin
                dut_clk_d = 1'b0;
                if (s1_q && r1_q) e1_d = jk_next(e1_q, j1_q, k1_q);
                if (s2_q && r2_q) e2_d = jk_next(e2_q, j2_q, k2_q);
                state_d = ST_WAIT_L;
            end
            ST_WAIT_L: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_CHECK: begin
                dut_clk_d = 1'b1;
                err_d     = err_sum[8] ? 8'hFF : err_sum[7:0];
                if ((mis1 || mis2) && !fail_seen_q) begin
                    fs_d        = step_q;
                    fail_seen_d = 1'b1;
                end
                if (step_q == STEP_LAST) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 8'd0);
                    s1_d    = 1'b1;
                    s2_d    = 1'b1;
                    r1_d    = 1'b1;
                    r2_d    = 1'b1;
                    j1_d    = 1'b0;
                    k1_d    = 1'b0;
                    j2_d    = 1'b0;
                    k2_d    = 1'b0;
                end else begin
                    step_d  = step_q + 8'd1;
                    state_d = ST_DRIVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset aborts any run and parks the DUT pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            step_q      <= 8'd0;
            lfsr_q      <= SEED;
            e1_q        <= 1'b0;
            e2_q        <= 1'b0;
            fail_seen_q <= 1'b0;
            s1_q        <= 1'b1;
            s2_q        <= 1'b1;
            r1_q        <= 1'b1;
            r2_q        <= 1'b1;
            j1_q        <= 1'b0;
            k1_q        <= 1'b0;
            j2_q        <= 1'b0;
            k2_q        <= 1'b0;
            dut_clk_q   <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= 8'd0;
            fs_q        <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            lfsr_q      <= lfsr_d;
            e1_q        <= e1_d;
            e2_q        <= e2_d;
            fail_seen_q <= fail_seen_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            r1_q        <= r1_d;
            r2_q        <= r2_d;
            j1_q        <= j1_d;
            k1_q        <= k1_d;
            j2_q        <= j2_d;
            k2_q        <= k2_d;
            dut_clk_q   <= dut_clk_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_q       <= err_d;
            fs_q        <= fs_d;
        end
    end

    assign s1        = s1_q;
    assign s2        = s2_q;
    assign r1        = r1_q;
    assign r2        = r2_q;
    assign j1        = j1_q;
    assign k1        = k1_q;
    assign j2        = j2_q;
    assign k2        = k2_q;
    assign clk1      = dut_clk_q;
    assign clk2      = dut_clk_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_cnt   = err_q;
    assign fail_step = fs_q;

endmodule

// File: tb/tb_hc112_tester.sv
// tb/tb_hc112_tester.sv - scoreboard bench for hc112_tester with behavioural HC112 models
module tb_hc112_tester;

    logic clk;
    logic rst_n;
    logic [2:0] start_w;
    logic [2:0] q1_w, q1n_w, q2_w, q2n_w;
    logic [2:0] s1_w, s2_w, r1_w, r2_w, j1_w, k1_w, j2_w, k2_w, c1_w, c2_w;
    logic [2:0] busy_w, done_w, pass_w;
    logic [7:0] err_w [3];
    logic [7:0] fs_w [3];
    logic [1:0] mode [3];

    int cyc;
    int n_vec;
    int n_err;

    typedef struct packed {
        logic [31:0] done_cyc;
        logic        pass;
        logic [7:0]  err;
        logic [7:0]  fs;
        logic        err_min;
    } exp_t;

    exp_t exp_q [3][$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Instance 0: defaults. Instance 1: 4 steps. Instance 2: 200 steps, SETTLE 1.
    hc112_tester #(.STEPS(64), .SETTLE(2), .SEED(8'hA5)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_w[0]),
        .q1(q1_w[0]), .q1_n(q1n_w[0]), .q2(q2_w[0]), .q2_n(q2n_w[0]),
        .s1(s1_w[0]), .s2(s2_w[0]), .r1(r1_w[0]), .r2(r2_w[0]),
        .j1(j1_w[0]), .k1(k1_w[0]), .j2(j2_w[0]), .k2(k2_w[0]),
        .clk1(c1_w[0]), .clk2(c2_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .pass(pass_w[0]), .err_cnt(err_w[0]), .fail_step(fs_w[0]));

    hc112_tester #(.STEPS(4), .SETTLE(2), .SEED(8'hA5)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_w[1]),
        .q1(q1_w[1]), .q1_n(q1n_w[1]), .q2(q2_w[1]), .q2_n(q2n_w[1]),
        .s1(s1_w[1]), .s2(s2_w[1]), .r1(r1_w[1]), .r2(r2_w[1]),
        .j1(j1_w[1]), .k1(k1_w[1]), .j2(j2_w[1]), .k2(k2_w[1]),
        .clk1(c1_w[1]), .clk2(c2_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .pass(pass_w[1]), .err_cnt(err_w[1]), .fail_step(fs_w[1]));

    hc112_tester #(.STEPS(200), .SETTLE(1), .SEED(8'hA5)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_w[2]),
        .q1(q1_w[2]), .q1_n(q1n_w[2]), .q2(q2_w[2]), .q2_n(q2n_w[2]),
        .s1(s1_w[2]), .s2(s2_w[2]), .r1(r1_w[2]), .r2(r2_w[2]),
        .j1(j1_w[2]), .k1(k1_w[2]), .j2(j2_w[2]), .k2(k2_w[2]),
        .clk1(c1_w[2]), .clk2(c2_w[2]), .busy(busy_w[2]), .done(done_w[2]),
        .pass(pass_w[2]), .err_cnt(err_w[2]), .fail_step(fs_w[2]));

    // Behavioural HC112 per instance with selectable output faults:
    // 0 good, 1 Q1 stuck at 0, 2 Q2_N tied to Q2, 3 both channels inverted.
    for (genvar g = 0; g < 3; g++) begin : g_model
        logic m1 = 1'b0;
        logic m2 = 1'b0;
        always @(negedge c1_w[g] or negedge s1_w[g] or negedge r1_w[g]) begin
            if (!s1_w[g])      m1 <= 1'b1;
            else if (!r1_w[g]) m1 <= 1'b0;
            else begin
                case ({j1_w[g], k1_w[g]})
                    2'b01:   m1 <= 1'b0;
                    2'b10:   m1 <= 1'b1;
                    2'b11:   m1 <= ~m1;
                    default: m1 <= m1;
                endcase
            end
        end
        always @(negedge c2_w[g] or negedge s2_w[g] or negedge r2_w[g]) begin
            if (!s2_w[g])      m2 <= 1'b1;
            else if (!r2_w[g]) m2 <= 1'b0;
            else begin
                case ({j2_w[g], k2_w[g]})
                    2'b01:   m2 <= 1'b0;
                    2'b10:   m2 <= 1'b1;
                    2'b11:   m2 <= ~m2;
                    default: m2 <= m2;
                endcase
            end
        end
        assign q1_w[g]  = (mode[g] == 2'd1) ? 1'b0 : ((mode[g] == 2'd3) ? ~m1 : m1);
        assign q1n_w[g] = (mode[g] == 2'd3) ? m1 : ~m1;
        assign q2_w[g]  = (mode[g] == 2'd3) ? ~m2 : m2;
        assign q2n_w[g] = (mode[g] == 2'd2 || mode[g] == 2'd3) ? m2 : ~m2;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic int run_len(input int i);
        case (i)
            0:       return 64 * 7 + 1;
            1:       return 4 * 7 + 1;
            default: return 200 * 5 + 1;
        endcase
    endfunction

    // Hand-computed pin vectors {s1,r1,j1,k1,s2,r2,j2,k2} for steps 0..6 from SEED A5
    // (LFSR values A5,4A,95,2A,54,A9,53); step 6 drives J1=K1=1.
    logic [7:0] vec_tbl [7] = '{8'h88, 8'h44, 8'hEE, 8'h9D, 8'hCE, 8'hED, 8'hFC};
    logic [2:0] done_prev = 3'b000;
    logic       c1_prev   = 1'b1;
    int         fall_idx  = 0;
    int         low_run   = 0;
    logic [7:0] vec0;
    assign vec0 = {s1_w[0], r1_w[0], j1_w[0], k1_w[0], s2_w[0], r2_w[0], j2_w[0], k2_w[0]};

    // Monitor: pops the scoreboard on each rising Done; tracks instance-0 DUT clocking.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (done_w[i] && !done_prev[i]) begin
                if (exp_q[i].size() == 0) begin
                    chk($sformatf("unexpected_done[%0d]", i), 1, 0);
                end else begin
                    e = exp_q[i].pop_front();
                    chk($sformatf("done_cycle[%0d]", i), cyc, int'(e.done_cyc));
                    chk($sformatf("busy_at_done[%0d]", i), busy_w[i], 0);
                    chk($sformatf("pass[%0d]", i), pass_w[i], e.pass);
                    if (e.err_min)
                        chk($sformatf("err_cnt_min[%0d]", i), (err_w[i] >= e.err) ? 1 : 0, 1);
                    else
                        chk($sformatf("err_cnt[%0d]", i), err_w[i], e.err);
                    chk($sformatf("fail_step[%0d]", i), fs_w[i], e.fs);
                end
            end
        end
        done_prev = done_w;
        if (c1_prev && !c1_w[0]) begin
            chk("clk2_follows_clk1", c2_w[0], 0);
            if (fall_idx < 7) chk($sformatf("step%0d_vector", fall_idx), vec0, vec_tbl[fall_idx]);
            fall_idx++;
        end
        if (!c1_w[0]) begin
            low_run++;
        end else if (!c1_prev) begin
            chk("clk1_low_cycles", low_run, 3);
            low_run = 0;
        end
        c1_prev = c1_w[0];
    end

    task automatic chk_pins(input int i);
        chk($sformatf("pins_idle[%0d]", i),
            {s1_w[i], s2_w[i], r1_w[i], r2_w[i], c1_w[i], c2_w[i],
             j1_w[i], k1_w[i], j2_w[i], k2_w[i]}, 10'h3F0);
    endtask

    task automatic chk_idle(input int i);
        chk_pins(i);
        chk($sformatf("status_idle[%0d]", i), {busy_w[i], done_w[i], pass_w[i]}, 0);
        chk($sformatf("err_idle[%0d]", i), err_w[i], 0);
        chk($sformatf("fs_idle[%0d]", i), fs_w[i], 0);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input int i, input logic p, input int err, input int fs, input logic emin);
        exp_t e;
        int   k;
        if (i == 0) fall_idx = 0;
        @(posedge clk);
        #1;
        start_w[i] = 1'b1;
        e.done_cyc = 32'(cyc + run_len(i));
        e.pass     = p;
        e.err      = 8'(err);
        e.fs       = 8'(fs);
        e.err_min  = emin;
        exp_q[i].push_back(e);
        @(posedge clk);
        #1;
        start_w[i] = 1'b0;
        chk($sformatf("busy_after_start[%0d]", i), busy_w[i], 1);
        k = 0;
        while (!done_w[i] && k < run_len(i) + 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk($sformatf("done_within_budget[%0d]", i), done_w[i], 1);
        @(negedge clk);
        @(negedge clk);
        chk_pins(i);
    endtask

    initial begin
        int c0;
        n_vec   = 0;
        n_err   = 0;
        cyc     = 0;
        rst_n   = 1'b0;
        start_w = 3'b000;
        mode[0] = 2'd0;
        mode[1] = 2'd2;
        mode[2] = 2'd3;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk_idle(i);

        // Good DUT, default parameters.
        run(0, 1'b1, 0, 0, 1'b0);
        // Q1 stuck at 0: first mismatch on the preset step.
        mode[0] = 2'd1;
        run(0, 1'b0, 1, 1, 1'b1);
        mode[0] = 2'd0;
        // Q2_N tied to Q2, 4 steps: channel 2 fails every check.
        run(1, 1'b0, 4, 0, 1'b0);
        // Always mismatching, 200 steps: error count saturates.
        run(2, 1'b0, 255, 0, 1'b0);

        // Restart attempt while busy, then abort with reset.
        fall_idx = 0;
        @(posedge clk);
        #1;
        start_w[0] = 1'b1;
        c0 = cyc;
        @(posedge clk);
        #1;
        start_w[0] = 1'b0;
        chk("abort_busy", busy_w[0], 1);
        wait_cyc(c0 + 20);
        start_w[0] = 1'b1;
        @(posedge clk);
        #1;
        start_w[0] = 1'b0;
        chk("restart_ignored_busy", busy_w[0], 1);
        wait_cyc(c0 + 100);
        rst_n = 1'b0;
        chk("abort_fall_count", fall_idx, 14);
        #2;
        chk_idle(0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle(0);

        // Fresh run after abort repeats the same sequence and result.
        run(0, 1'b1, 0, 0, 1'b0);

        for (int i = 0; i < 3; i++) chk($sformatf("scoreboard_empty[%0d]", i), exp_q[i].size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
